lsu1: RTL and testbench

- Memory-request stage of the load/store path, in the EX/MEM boundary.
- Turns the EX-stage load/store decode (ls_ena, ls_sel, address, rt data) into one SRAM-like data-bus transaction: byte strobes, aligned write data, size.
- Tracks the transaction to completion and registers the returned word as data_ram_rdata for the MEM-stage load formatter.
- Drives a stall request to the pipeline controller while a transaction is outstanding.

---
 rtl/lsu1_pkg.sv | 42 ++++
 rtl/lsu1_if.sv | 24 ++
 rtl/lsu1_store_align.sv | 64 ++++++
 rtl/lsu1.sv | 107 ++++++++++
 tb/tb_lsu1.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu1_pkg.sv
// Shared load/store definitions: LS_SEL codes, bus size codes, LSU states and request record.
package lsu1_pkg;

    localparam logic [3:0] LS_SEL_LB  = 4'd0;
    localparam logic [3:0] LS_SEL_LBU = 4'd1;
    localparam logic [3:0] LS_SEL_LH  = 4'd2;
    localparam logic [3:0] LS_SEL_LHU = 4'd3;
    localparam logic [3:0] LS_SEL_LW  = 4'd4;
    localparam logic [3:0] LS_SEL_LWL = 4'd5;
    localparam logic [3:0] LS_SEL_LWR = 4'd6;
    localparam logic [3:0] LS_SEL_SB  = 4'd7;
    localparam logic [3:0] LS_SEL_SH  = 4'd8;
    localparam logic [3:0] LS_SEL_SW  = 4'd9;
    localparam logic [3:0] LS_SEL_SWL = 4'd10;
    localparam logic [3:0] LS_SEL_SWR = 4'd11;

    localparam logic [1:0] DSIZE_BYTE = 2'd0;
    localparam logic [1:0] DSIZE_HALF = 2'd1;
    localparam logic [1:0] DSIZE_WORD = 2'd2;

    typedef enum logic [2:0] {
        StIdle,
        StWaitAddr,
        StWaitData,
        StHold,
        StDiscard
    } lsu_state_e;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } lsu_req_t;

    // Store codes occupy a contiguous range after the loads.
    function automatic logic ls_is_store(input logic [3:0] sel);
        return (sel >= LS_SEL_SB) && (sel <= LS_SEL_SWR);
    endfunction

endpackage

// File: rtl/lsu1_if.sv
// SRAM-like data bus between the LSU (master) and the data memory side (slave).
interface lsu1_if;

    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata
    );

endinterface

// File: rtl/lsu1_store_align.sv
// Combinational request formatter: byte strobes, lane-aligned store data, size and bus address.
module lsu1_store_align
    import lsu1_pkg::*;
(
    input  logic [3:0]  i_ls_sel,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_rt,
    output logic        o_wr,
    output logic [1:0]  o_size,
    output logic [31:0] o_addr,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_wdata
);

    // Decode the access; loads keep wstrb 0 and drive no store data.
    always_comb begin
        o_wr    = ls_is_store(i_ls_sel);
        o_size  = DSIZE_WORD;
        o_addr  = i_addr;
        o_wstrb = 4'b0000;
        o_wdata = 32'h0;
        case (i_ls_sel)
            LS_SEL_LB, LS_SEL_LBU: o_size = DSIZE_BYTE;
            LS_SEL_LH, LS_SEL_LHU: o_size = DSIZE_HALF;
            LS_SEL_LW:             o_size = DSIZE_WORD;
            LS_SEL_LWL, LS_SEL_LWR: o_addr = {i_addr[31:2], 2'b00};
            LS_SEL_SB: begin
                o_size  = DSIZE_BYTE;
                o_wstrb = 4'b0001 << i_addr[1:0];
                o_wdata = {4{i_rt[7:0]}};
            end
            LS_SEL_SH: begin
                o_size  = DSIZE_HALF;
                o_wstrb = i_addr[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_rt[15:0]}};
            end
            LS_SEL_SW: begin
                o_wstrb = 4'b1111;
                o_wdata = i_rt;
            end
            // Unaligned-word stores: the left part lands in the low lanes.
            LS_SEL_SWL: begin
                o_addr = {i_addr[31:2], 2'b00};
                case (i_addr[1:0])
                    2'b00: begin o_wstrb = 4'b0001; o_wdata = {24'h0, i_rt[31:24]}; end
                    2'b01: begin o_wstrb = 4'b0011; o_wdata = {16'h0, i_rt[31:16]}; end
                    2'b10: begin o_wstrb = 4'b0111; o_wdata = {8'h0, i_rt[31:8]}; end
                    default: begin o_wstrb = 4'b1111; o_wdata = i_rt; end
                endcase
            end
            LS_SEL_SWR: begin
                o_addr = {i_addr[31:2], 2'b00};
                case (i_addr[1:0])
                    2'b00: begin o_wstrb = 4'b1111; o_wdata = i_rt; end
                    2'b01: begin o_wstrb = 4'b1110; o_wdata = {i_rt[23:0], 8'h0}; end
                    2'b10: begin o_wstrb = 4'b1100; o_wdata = {i_rt[15:0], 16'h0}; end
                    default: begin o_wstrb = 4'b1000; o_wdata = {i_rt[7:0], 24'h0}; end
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu1.sv
// Memory-request stage: issues one data-bus transaction per EX load/store, tracks it to
// completion, registers the load word for MEM and stalls the pipe while it is outstanding.
module lsu1
    import lsu1_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_ls_ena,
    input  logic [3:0]  ex_ls_sel,
    input  logic [31:0] ex_ls_addr,
    input  logic [31:0] ex_rt_data,
    input  logic        ex_has_exception,
    input  logic        pipe_advance,
    input  logic        flush,
    lsu1_if.master      bus,
    output logic [31:0] data_ram_rdata,
    output logic        lsu_stall_req
);

    lsu_state_e  r_state;
    lsu_req_t    r_req;
    logic [31:0] r_ram_rdata;
    lsu_req_t    w_ex_req;
    lsu_req_t    w_bus_req;
    logic        w_go;

    assign w_go = ex_ls_ena & ~ex_has_exception & ~flush;

    lsu1_store_align u_align (
        .i_ls_sel (ex_ls_sel),
        .i_addr   (ex_ls_addr),
        .i_rt     (ex_rt_data),
        .o_wr     (w_ex_req.wr),
        .o_size   (w_ex_req.size),
        .o_addr   (w_ex_req.addr),
        .o_wstrb  (w_ex_req.wstrb),
        .o_wdata  (w_ex_req.wdata)
    );

    // Transaction FSM; request fields are captured in the go cycle and replayed while waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_req       <= '0;
            r_ram_rdata <= 32'h0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_go) begin
                        r_req   <= w_ex_req;
                        r_state <= bus.data_addr_ok ? StWaitData : StWaitAddr;
                    end
                end
                StWaitAddr: begin
                    // Accepted in the flush cycle: the response still has to be drained.
                    if (bus.data_addr_ok) begin
                        r_state <= flush ? StDiscard : StWaitData;
                    end else if (flush) begin
                        r_state <= StIdle;
                    end
                end
                StWaitData: begin
                    if (bus.data_data_ok) begin
                        if (!r_req.wr) begin
                            r_ram_rdata <= bus.data_rdata;
                        end
                        r_state <= pipe_advance ? StIdle : StHold;
                    end else if (flush) begin
                        r_state <= StDiscard;
                    end
                end
                StHold: begin
                    if (pipe_advance || flush) begin
                        r_state <= StIdle;
                    end
                end
                StDiscard: begin
                    if (bus.data_data_ok) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // In IDLE the request goes straight from EX; afterwards it comes from the capture register.
    always_comb begin
        w_bus_req = (r_state == StIdle) ? w_ex_req : r_req;
    end

    // Bus request and stall; both are forced low while reset is asserted.
    always_comb begin
        bus.data_req  = ~rst & (((r_state == StIdle) & w_go) | (r_state == StWaitAddr));
        lsu_stall_req = ~rst & (((r_state == StIdle) & w_go) | (r_state == StWaitAddr) |
                                ((r_state == StWaitData) & ~bus.data_data_ok) |
                                (r_state == StDiscard));
    end

    assign bus.data_wr    = w_bus_req.wr;
    assign bus.data_size  = w_bus_req.size;
    assign bus.data_addr  = w_bus_req.addr;
    assign bus.data_wstrb = w_bus_req.wstrb;
    assign bus.data_wdata = w_bus_req.wdata;
    assign data_ram_rdata = r_ram_rdata;

endmodule

// File: tb/tb_lsu1.sv
// Self-checking bench for lsu1: vector table for request formatting plus hand-written
// sequences for delayed handshakes, HOLD, DISCARD, exceptions and reset mid-transaction.
module tb_lsu1;
    import lsu1_pkg::*;

    typedef struct {
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] rt;
        logic [31:0] e_addr;
        logic [1:0]  e_size;
        logic [3:0]  e_wstrb;
        logic [31:0] e_wdata;
        logic        e_wr;
    } vec_t;

    localparam int NV = 12;

    logic        clk;
    logic        rst;
    logic        ex_ls_ena;
    logic [3:0]  ex_ls_sel;
    logic [31:0] ex_ls_addr;
    logic [31:0] ex_rt_data;
    logic        ex_has_exception;
    logic        pipe_advance;
    logic        flush;
    logic [31:0] data_ram_rdata;
    logic        lsu_stall_req;

    int          n_checks = 0;
    int          n_fail   = 0;
    vec_t        vec[NV];
    vec_t        exp_q[$];
    logic [31:0] rd_q[$];
    logic [31:0] last_ram;
    vec_t        e;
    int          n_stall;
    logic [31:0] rv;

    lsu1_if bus ();

    lsu1 dut (
        .clk              (clk),
        .rst              (rst),
        .ex_ls_ena        (ex_ls_ena),
        .ex_ls_sel        (ex_ls_sel),
        .ex_ls_addr       (ex_ls_addr),
        .ex_rt_data       (ex_rt_data),
        .ex_has_exception (ex_has_exception),
        .pipe_advance     (pipe_advance),
        .flush            (flush),
        .bus              (bus),
        .data_ram_rdata   (data_ram_rdata),
        .lsu_stall_req    (lsu_stall_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required $finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        ex_ls_ena        = 1'b0;
        ex_ls_sel        = LS_SEL_LW;
        ex_ls_addr       = 32'h0;
        ex_rt_data       = 32'h0;
        ex_has_exception = 1'b0;
        pipe_advance     = 1'b1;
        flush            = 1'b0;
        bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b0;
        bus.data_rdata   = 32'h0;
    endtask

    task automatic drive_ls(input logic [3:0] sel, input logic [31:0] addr,
                            input logic [31:0] rt);
        ex_ls_ena  = 1'b1;
        ex_ls_sel  = sel;
        ex_ls_addr = addr;
        ex_rt_data = rt;
    endtask

    initial begin
        vec[0]  = '{LS_SEL_SB,  32'h1003, 32'hAABBCCDD, 32'h1003, 2'd0, 4'b1000, 32'hDDDDDDDD, 1'b1};
        vec[1]  = '{LS_SEL_SWL, 32'h3001, 32'h11223344, 32'h3000, 2'd2, 4'b0011, 32'h00001122, 1'b1};
        vec[2]  = '{LS_SEL_SWR, 32'h3002, 32'h11223344, 32'h3000, 2'd2, 4'b1100, 32'h33440000, 1'b1};
        vec[3]  = '{LS_SEL_SH,  32'h4002, 32'h0000BEEF, 32'h4002, 2'd1, 4'b1100, 32'hBEEFBEEF, 1'b1};
        vec[4]  = '{LS_SEL_SW,  32'h5000, 32'hCAFEF00D, 32'h5000, 2'd2, 4'b1111, 32'hCAFEF00D, 1'b1};
        vec[5]  = '{LS_SEL_SWL, 32'h3003, 32'h11223344, 32'h3000, 2'd2, 4'b1111, 32'h11223344, 1'b1};
        vec[6]  = '{LS_SEL_SWR, 32'h3000, 32'h11223344, 32'h3000, 2'd2, 4'b1111, 32'h11223344, 1'b1};
        vec[7]  = '{LS_SEL_SWL, 32'h3000, 32'h11223344, 32'h3000, 2'd2, 4'b0001, 32'h00000011, 1'b1};
        vec[8]  = '{LS_SEL_SWR, 32'h3003, 32'h11223344, 32'h3000, 2'd2, 4'b1000, 32'h44000000, 1'b1};
        vec[9]  = '{LS_SEL_LBU, 32'h6001, 32'h0,        32'h6001, 2'd0, 4'b0000, 32'h0,        1'b0};
        vec[10] = '{LS_SEL_LWL, 32'h6003, 32'h0,        32'h6000, 2'd2, 4'b0000, 32'h0,        1'b0};
        vec[11] = '{LS_SEL_LH,  32'h6002, 32'h0,        32'h6002, 2'd1, 4'b0000, 32'h0,        1'b0};

        // Reset with a live load presented: nothing may leak out.
        rst = 1'b1;
        drive_idle();
        drive_ls(LS_SEL_LW, 32'h100, 32'h0);
        #3;
        check("reset req", {31'h0, bus.data_req}, 32'h0);
        check("reset stall", {31'h0, lsu_stall_req}, 32'h0);
        check("reset rdata", data_ram_rdata, 32'h0);
        last_ram = 32'h0;
        step();
        step();
        rst = 1'b0;
        drive_idle();

        // Table: request same-cycle accepted, response next cycle.
        for (int i = 0; i < NV; i++) begin
            step();
            drive_idle();
            drive_ls(vec[i].sel, vec[i].addr, vec[i].rt);
            bus.data_addr_ok = 1'b1;
            exp_q.push_back(vec[i]);
            #1;
            e = exp_q.pop_front();
            check("vec req", {31'h0, bus.data_req}, 32'h1);
            check("vec addr", bus.data_addr, e.e_addr);
            check("vec size", {30'h0, bus.data_size}, {30'h0, e.e_size});
            check("vec wstrb", {28'h0, bus.data_wstrb}, {28'h0, e.e_wstrb});
            check("vec wr", {31'h0, bus.data_wr}, {31'h0, e.e_wr});
            if (e.e_wr) check("vec wdata", bus.data_wdata, e.e_wdata);
            check("vec stall issue", {31'h0, lsu_stall_req}, 32'h1);
            step();
            drive_idle();
            bus.data_data_ok = 1'b1;
            rv = 32'hA5000000 | i;
            bus.data_rdata = rv;
            if (!vec[i].e_wr) rd_q.push_back(rv);
            #1;
            check("vec req done", {31'h0, bus.data_req}, 32'h0);
            check("vec stall done", {31'h0, lsu_stall_req}, 32'h0);
            step();
            drive_idle();
            #1;
            if (!vec[i].e_wr) last_ram = rd_q.pop_front();
            check("vec ram rdata", data_ram_rdata, last_ram);
        end

        // LW with addr_ok three cycles late and data_ok three cycles after that.
        n_stall = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            drive_idle();
            if (c == 0) drive_ls(LS_SEL_LW, 32'h2000, 32'h0);
            else if (c <= 3) drive_ls(LS_SEL_SB, 32'hFFFFFFF1, 32'h5555AAAA);
            bus.data_addr_ok = (c == 3);
            bus.data_data_ok = (c == 6);
            if (c == 6) begin
                bus.data_rdata = 32'h12345678;
                rd_q.push_back(32'h12345678);
            end
            #1;
            if (lsu_stall_req) n_stall++;
            if (c <= 3) begin
                check("lw req", {31'h0, bus.data_req}, 32'h1);
                check("lw addr", bus.data_addr, 32'h2000);
                check("lw size", {30'h0, bus.data_size}, 32'h2);
                check("lw wr", {31'h0, bus.data_wr}, 32'h0);
            end else begin
                check("lw req off", {31'h0, bus.data_req}, 32'h0);
            end
            if (c == 7) begin
                last_ram = rd_q.pop_front();
                check("lw ram rdata", data_ram_rdata, last_ram);
            end
        end
        check("lw stall cycles", n_stall, 6);

        // Completion without pipe_advance parks in HOLD.
        step();
        drive_idle();
        drive_ls(LS_SEL_LW, 32'h2004, 32'h0);
        bus.data_addr_ok = 1'b1;
        #1;
        check("hold req", {31'h0, bus.data_req}, 32'h1);
        step();
        drive_idle();
        drive_ls(LS_SEL_LW, 32'h2004, 32'h0);
        pipe_advance = 1'b0;
        bus.data_data_ok = 1'b1;
        bus.data_rdata = 32'h55AA55AA;
        rd_q.push_back(32'h55AA55AA);
        #1;
        check("hold stall at data_ok", {31'h0, lsu_stall_req}, 32'h0);
        last_ram = rd_q.pop_front();
        for (int k = 0; k < 2; k++) begin
            step();
            drive_idle();
            drive_ls(LS_SEL_LW, 32'h2004, 32'h0);
            pipe_advance = 1'b0;
            #1;
            check("hold stall", {31'h0, lsu_stall_req}, 32'h0);
            check("hold no req", {31'h0, bus.data_req}, 32'h0);
            check("hold ram rdata", data_ram_rdata, last_ram);
        end
        step();
        drive_idle();
        drive_ls(LS_SEL_LW, 32'h2004, 32'h0);
        #1;
        check("hold release req", {31'h0, bus.data_req}, 32'h0);
        // Back in IDLE: a new request appears, then gets flushed before acceptance.
        step();
        drive_idle();
        drive_ls(LS_SEL_LB, 32'h7000, 32'h0);
        #1;
        check("idle after hold req", {31'h0, bus.data_req}, 32'h1);
        check("idle after hold stall", {31'h0, lsu_stall_req}, 32'h1);
        step();
        drive_idle();
        flush = 1'b1;
        #1;
        check("wait_addr flush req", {31'h0, bus.data_req}, 32'h1);
        check("wait_addr flush addr", bus.data_addr, 32'h7000);
        step();
        drive_idle();
        #1;
        check("flushed req", {31'h0, bus.data_req}, 32'h0);
        check("flushed stall", {31'h0, lsu_stall_req}, 32'h0);

        // Flush while waiting for data: response must be drained and dropped.
        step();
        drive_idle();
        drive_ls(LS_SEL_LW, 32'h2008, 32'h0);
        bus.data_addr_ok = 1'b1;
        #1;
        check("disc req", {31'h0, bus.data_req}, 32'h1);
        step();
        drive_idle();
        flush = 1'b1;
        #1;
        check("disc flush stall", {31'h0, lsu_stall_req}, 32'h1);
        for (int k = 0; k < 2; k++) begin
            step();
            drive_idle();
            drive_ls(LS_SEL_LW, 32'h9000, 32'h0);
            #1;
            check("disc no req", {31'h0, bus.data_req}, 32'h0);
            check("disc stall", {31'h0, lsu_stall_req}, 32'h1);
        end
        step();
        drive_idle();
        drive_ls(LS_SEL_LW, 32'h9000, 32'h0);
        bus.data_data_ok = 1'b1;
        bus.data_rdata = 32'hDEADBEEF;
        #1;
        check("disc data_ok req", {31'h0, bus.data_req}, 32'h0);
        check("disc data_ok stall", {31'h0, lsu_stall_req}, 32'h1);
        step();
        drive_idle();
        #1;
        check("disc ram kept", data_ram_rdata, last_ram);
        check("disc idle stall", {31'h0, lsu_stall_req}, 32'h0);

        // Faulted or flushed EX instructions never reach the bus.
        step();
        drive_idle();
        drive_ls(LS_SEL_LW, 32'h2010, 32'h0);
        ex_has_exception = 1'b1;
        #1;
        check("exc req", {31'h0, bus.data_req}, 32'h0);
        check("exc stall", {31'h0, lsu_stall_req}, 32'h0);
        step();
        drive_idle();
        drive_ls(LS_SEL_SW, 32'h2010, 32'h1);
        flush = 1'b1;
        #1;
        check("flush ex req", {31'h0, bus.data_req}, 32'h0);
        check("flush ex stall", {31'h0, lsu_stall_req}, 32'h0);

        // Reset asserted while waiting for data.
        step();
        drive_idle();
        drive_ls(LS_SEL_LW, 32'h200C, 32'h0);
        bus.data_addr_ok = 1'b1;
        #1;
        check("rst seq req", {31'h0, bus.data_req}, 32'h1);
        step();
        drive_idle();
        drive_ls(LS_SEL_LW, 32'h200C, 32'h0);
        #1;
        check("rst seq wait stall", {31'h0, lsu_stall_req}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("mid rst stall", {31'h0, lsu_stall_req}, 32'h0);
        check("mid rst req", {31'h0, bus.data_req}, 32'h0);
        check("mid rst rdata", data_ram_rdata, 32'h0);
        step();
        rst = 1'b0;
        drive_idle();
        #1;
        check("post rst stall", {31'h0, lsu_stall_req}, 32'h0);
        step();
        drive_idle();
        drive_ls(LS_SEL_LB, 32'h8001, 32'h0);
        bus.data_addr_ok = 1'b1;
        #1;
        check("post rst new req", {31'h0, bus.data_req}, 32'h1);
        step();
        drive_idle();
        bus.data_data_ok = 1'b1;
        bus.data_rdata = 32'h00000077;
        #1;
        step();
        drive_idle();
        #1;
        check("post rst load", data_ram_rdata, 32'h00000077);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
